// File: rtl/eeg_pkg.sv
// Shared types and constants for the chip output-pad arbiter.
package eeg_pkg;

  localparam int CHIP_OUT_DW = 8;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 32'd1 >= n) ? 32'd0 : v + 32'd1;
  endfunction

endpackage

// File: rtl/eeg_rr_pick.sv
// Combinational round-robin first-one finder: first set req bit at or above ptr, wrapping.
// No state, zero latency; any is low when no request is pending.
module eeg_rr_pick
  import eeg_pkg::*;
#(
  parameter int REQ_NUM = 2,
  parameter int SID_W   = $clog2(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req,
  input  logic [SID_W-1:0]   ptr,
  output logic [SID_W-1:0]   gnt,
  output logic               any
);

  logic [SID_W-1:0] cand;

  always_comb begin
    gnt  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int k = 0; k < REQ_NUM; k++) begin
      cand = SID_W'((int'(ptr) + k) % REQ_NUM);
      if (!any && req[cand]) begin
        gnt = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eeg_out_arb.sv
// Packet-level round-robin arbiter onto the single output pad stream; 1-cycle registered latency.
// Output beat held while OUT_VLD && !OUT_RDY; SRC_RDY follows slot_free for the granted source only.
module eeg_out_arb
  import eeg_pkg::*;
#(
  parameter int REQ_NUM   = 2,
  parameter int MAX_BEATS = 256,
  parameter int SID_W     = $clog2(REQ_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [REQ_NUM-1:0]             SRC_VLD,
  input  logic [REQ_NUM-1:0]             SRC_LST,
  output logic [REQ_NUM-1:0]             SRC_RDY,
  input  logic [REQ_NUM*CHIP_OUT_DW-1:0] SRC_DAT,
  output logic                           OUT_VLD,
  output logic                           OUT_LST,
  input  logic                           OUT_RDY,
  output logic [CHIP_OUT_DW-1:0]         OUT_DAT,
  output logic [SID_W-1:0]               OUT_SID,
  output logic                           ARB_BUSY,
  output logic                           ERR_OVF,
  input  logic                           ERR_CLR
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_t             state_q, state_d;
  logic [SID_W-1:0]       ptr_q, ptr_d;
  logic [SID_W-1:0]       gnt_q, gnt_d;
  logic [SID_W-1:0]       pick_gnt, sel;
  logic                   pick_any;
  logic                   slot_free, sel_vld, sel_lst, xfer, ovf_hit, end_pkt;
  logic [CNT_W-1:0]       cnt_q, beat_num;
  logic [CHIP_OUT_DW-1:0] sel_dat;

  eeg_rr_pick #(
    .REQ_NUM(REQ_NUM),
    .SID_W  (SID_W)
  ) u_pick (
    .req(SRC_VLD),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .any(pick_any)
  );

  // While locked, only the owner is looked at; other requesters wait for IDLE.
  assign slot_free = !OUT_VLD || OUT_RDY;
  assign sel       = (state_q == LOCK) ? gnt_q : pick_gnt;
  assign sel_vld   = SRC_VLD[sel];
  assign sel_lst   = SRC_LST[sel];
  assign sel_dat   = SRC_DAT[int'(sel) * CHIP_OUT_DW +: CHIP_OUT_DW];
  assign xfer      = sel_vld && slot_free;

  assign beat_num = (state_q == LOCK) ? cnt_q + CNT_W'(1) : CNT_W'(1);
  assign ovf_hit  = xfer && !sel_lst && (beat_num == CNT_W'(MAX_BEATS));
  assign end_pkt  = sel_lst || ovf_hit;
  assign ARB_BUSY = (state_q == LOCK);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    SRC_RDY = '0;
    if (!rst) begin
      SRC_RDY[sel] = slot_free && ((state_q == LOCK) || pick_any);
    end
    if (xfer) begin
      if (end_pkt) begin
        state_d = IDLE;
        ptr_d   = SID_W'(wrap_inc(32'(sel), REQ_NUM));
      end else begin
        state_d = LOCK;
        gnt_d   = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q <= beat_num;
    end
  end

  // A runaway packet is closed on the output with a forced last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT_VLD <= 1'b0;
      OUT_LST <= 1'b0;
      OUT_DAT <= '0;
      OUT_SID <= '0;
    end else if (xfer) begin
      OUT_VLD <= 1'b1;
      OUT_LST <= end_pkt;
      OUT_DAT <= sel_dat;
      OUT_SID <= sel;
    end else if (OUT_RDY) begin
      OUT_VLD <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ERR_OVF <= 1'b0;
    end else if (ovf_hit) begin
      ERR_OVF <= 1'b1;
    end else if (ERR_CLR) begin
      ERR_OVF <= 1'b0;
    end
  end

endmodule
